// File: rtl/merge_pkg.sv
`default_nettype none
// =============================================================================
// merge_pkg : shared arbitration-mode constants and source-id width helper
// Rev 1.0
// =============================================================================
package merge_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Source-id width: at least one bit, even for a single channel.
    function automatic int sid_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage : merge_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// =============================================================================
// rr_arbiter : combinational one-hot grant, fixed-priority or round-robin
// Rev 1.0
// =============================================================================
module rr_arbiter
    import merge_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             advance,
    output logic [WIDTH-1:0] grant
);

    localparam int SIDW = sid_width(WIDTH);

    generate
        if (WIDTH == 1) begin : g_single
            assign grant = req;
        end else begin : g_multi
            logic [SIDW-1:0] r_ptr;
            logic [SIDW-1:0] w_start;
            logic [SIDW-1:0] w_gidx;
            logic            w_found;

            assign w_start = (ARB_MODE == ARB_FIXED) ? '0 : r_ptr;

            // Scan upward from the start index, wrapping past WIDTH-1.
            always_comb begin
                int j;
                j       = 0;
                grant   = '0;
                w_gidx  = '0;
                w_found = 1'b0;
                for (int i = 0; i < WIDTH; i++) begin
                    j = int'(w_start) + i;
                    if (j >= WIDTH) begin
                        j = j - WIDTH;
                    end
                    if (!w_found && req[j]) begin
                        grant[j] = 1'b1;
                        w_gidx   = SIDW'(j);
                        w_found  = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ptr <= '0;
                end else if (advance && w_found) begin
                    r_ptr <= (w_gidx == SIDW'(WIDTH - 1)) ? '0 : w_gidx + 1'b1;
                end
            end
        end
    endgenerate

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/arb_merge.sv
`default_nettype none
// =============================================================================
// arb_merge : N-to-1 valid/ready merge with arbiter and 2-entry output FIFO
// Rev 1.0
// =============================================================================
module arb_merge
    import merge_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int DATAWIDTH = 32,
    parameter  int ARB_MODE  = ARB_RR,
    localparam int SIDW      = sid_width(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     v_vld,
    input  logic [DATAWIDTH-1:0] v_pld [WIDTH],
    output logic [WIDTH-1:0]     v_rdy,
    output logic                 vld,
    output logic [DATAWIDTH-1:0] pld,
    output logic [SIDW-1:0]      sid,
    input  logic                 rdy
);

    logic [WIDTH-1:0]     w_grant;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic [SIDW-1:0]      w_gidx;
    logic [DATAWIDTH-1:0] w_gpld;

    logic [1:0]           r_count;
    logic                 r_wr;
    logic                 r_rd;
    logic [DATAWIDTH-1:0] r_pld [2];
    logic [SIDW-1:0]      r_sid [2];

    rr_arbiter #(
        .WIDTH    (WIDTH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (v_vld),
        .advance (w_push),
        .grant   (w_grant)
    );

    // Ready is also forced low while reset is held, not just when full.
    assign w_full = (r_count == 2'd2);
    assign v_rdy  = (rst || w_full) ? '0 : w_grant;
    assign w_push = |v_rdy;
    assign w_pop  = vld && rdy;

    always_comb begin
        w_gidx = '0;
        w_gpld = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_grant[i]) begin
                w_gidx = w_gidx | SIDW'(i);
                w_gpld = w_gpld | v_pld[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_pld[i] <= '0;
                r_sid[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_pld[r_wr] <= w_gpld;
                r_sid[r_wr] <= w_gidx;
                r_wr        <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign vld = (r_count != 2'd0);
    assign pld = r_pld[r_rd];
    assign sid = r_sid[r_rd];

endmodule : arb_merge
`default_nettype wire

// File: tb/tb_arb_merge.sv
`default_nettype none
// =============================================================================
// tb_arb_merge : directed-vector bench for arb_merge (round-robin and fixed)
// Rev 1.0
// =============================================================================
module tb_arb_merge;

    logic        clk;
    logic        rst;
    logic [3:0]  v_vld;
    logic [31:0] v_pld [4];
    logic [3:0]  v_rdy;
    logic        vld;
    logic [31:0] pld;
    logic [1:0]  sid;
    logic        rdy;

    logic [3:0]  v_vld0;
    logic [31:0] v_pld0 [4];
    logic [3:0]  v_rdy0;
    logic        vld0;
    logic [31:0] pld0;
    logic [1:0]  sid0;
    logic        rdy0;

    int nvec = 0;
    int nerr = 0;

    arb_merge #(.WIDTH(4), .DATAWIDTH(32), .ARB_MODE(1)) u_dut_rr (
        .clk(clk), .rst(rst), .v_vld(v_vld), .v_pld(v_pld), .v_rdy(v_rdy),
        .vld(vld), .pld(pld), .sid(sid), .rdy(rdy)
    );

    arb_merge #(.WIDTH(4), .DATAWIDTH(32), .ARB_MODE(0)) u_dut_fx (
        .clk(clk), .rst(rst), .v_vld(v_vld0), .v_pld(v_pld0), .v_rdy(v_rdy0),
        .vld(vld0), .pld(pld0), .sid(sid0), .rdy(rdy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; v_vld = 4'hF; rdy = 1'b1;
        step(); step();
        nvec++; if (vld !== 1'b0) begin nerr++; $display("FAIL reset_vld: got %b want 0", vld); end
        nvec++; if (pld !== 32'h0) begin nerr++; $display("FAIL reset_pld: got %h want 0", pld); end
        nvec++; if (sid !== 2'd0) begin nerr++; $display("FAIL reset_sid: got %0d want 0", sid); end
        nvec++; if (v_rdy !== 4'b0000) begin nerr++; $display("FAIL reset_v_rdy: got %b want 0000", v_rdy); end
        v_vld = 4'h0; rdy = 1'b0; rst = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 4; i++) v_pld[i] = 32'h100 + 32'(i);
        v_vld = 4'hF; rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            nvec++; if (v_rdy !== 4'(1 << (k % 4))) begin nerr++; $display("FAIL rr_grant[%0d]: got %b want %b", k, v_rdy, 4'(1 << (k % 4))); end
            step();
            nvec++; if (vld !== 1'b1) begin nerr++; $display("FAIL rr_vld[%0d]: got %b want 1", k, vld); end
            nvec++; if (sid !== 2'(k % 4)) begin nerr++; $display("FAIL rr_sid[%0d]: got %0d want %0d", k, sid, k % 4); end
            nvec++; if (pld !== 32'h100 + 32'(k % 4)) begin nerr++; $display("FAIL rr_pld[%0d]: got %h want %h", k, pld, 32'h100 + 32'(k % 4)); end
        end
        v_vld = 4'h0;
        step();
        nvec++; if (vld !== 1'b0) begin nerr++; $display("FAIL rr_drain: got %b want 0", vld); end
    endtask

    task automatic test_hold();
        rdy = 1'b0;
        v_pld[0] = 32'hA5; v_vld = 4'b0001;
        step();
        v_pld[0] = 32'h5A;
        #1;
        nvec++; if (v_rdy !== 4'b0001) begin nerr++; $display("FAIL hold_second_grant: got %b want 0001", v_rdy); end
        step();
        v_vld = 4'hF;
        #1;
        nvec++; if (v_rdy !== 4'b0000) begin nerr++; $display("FAIL hold_full_rdy: got %b want 0000", v_rdy); end
        nvec++; if (pld !== 32'hA5) begin nerr++; $display("FAIL hold_pld: got %h want a5", pld); end
        step();
        nvec++; if (pld !== 32'hA5 || vld !== 1'b1) begin nerr++; $display("FAIL hold_stable: got %h/%b want a5/1", pld, vld); end
        v_vld = 4'h0; rdy = 1'b1;
        step();
        nvec++; if (pld !== 32'h5A || vld !== 1'b1) begin nerr++; $display("FAIL hold_second_out: got %h/%b want 5a/1", pld, vld); end
        step();
        nvec++; if (vld !== 1'b0) begin nerr++; $display("FAIL hold_drain: got %b want 0", vld); end
    endtask

    // Pointer is 1 on entry.
    task automatic test_wrap();
        rdy = 1'b1;
        v_pld[0] = 32'h200; v_pld[1] = 32'h211; v_pld[2] = 32'h222;
        v_vld = 4'b0100;
        #1;
        nvec++; if (v_rdy !== 4'b0100) begin nerr++; $display("FAIL wrap_pre: got %b want 0100", v_rdy); end
        step();
        v_vld = 4'b0011;
        #1;
        nvec++; if (v_rdy !== 4'b0001) begin nerr++; $display("FAIL wrap_grant0: got %b want 0001", v_rdy); end
        nvec++; if (sid !== 2'd2 || pld !== 32'h222) begin nerr++; $display("FAIL wrap_out2: got %0d/%h want 2/222", sid, pld); end
        step();
        nvec++; if (sid !== 2'd0 || pld !== 32'h200) begin nerr++; $display("FAIL wrap_out0: got %0d/%h want 0/200", sid, pld); end
        nvec++; if (v_rdy !== 4'b0010) begin nerr++; $display("FAIL wrap_ptr1: got %b want 0010", v_rdy); end
        step();
        nvec++; if (sid !== 2'd1 || pld !== 32'h211) begin nerr++; $display("FAIL wrap_out1: got %0d/%h want 1/211", sid, pld); end
        nvec++; if (v_rdy !== 4'b0001) begin nerr++; $display("FAIL wrap_ptr2: got %b want 0001", v_rdy); end
        v_vld = 4'h0;
        step();
        nvec++; if (vld !== 1'b0) begin nerr++; $display("FAIL wrap_drain: got %b want 0", vld); end
    endtask

    // Pointer is 2 on entry; a withdrawn request must not move it.
    task automatic test_drop();
        v_vld = 4'b1000;
        #1;
        nvec++; if (v_rdy !== 4'b1000) begin nerr++; $display("FAIL drop_grant: got %b want 1000", v_rdy); end
        v_vld = 4'h0;
        step();
        nvec++; if (vld !== 1'b0) begin nerr++; $display("FAIL drop_vld: got %b want 0", vld); end
        v_vld = 4'b0110;
        #1;
        nvec++; if (v_rdy !== 4'b0100) begin nerr++; $display("FAIL drop_ptr_held: got %b want 0100", v_rdy); end
        v_vld = 4'h0;
        step();
    endtask

    task automatic test_reset_mid();
        rdy = 1'b0;
        v_pld[1] = 32'h3C1; v_pld[2] = 32'h3C2;
        v_vld = 4'b0100;
        step();
        v_vld = 4'b0010;
        #1;
        nvec++; if (v_rdy !== 4'b0010) begin nerr++; $display("FAIL rmid_grant1: got %b want 0010", v_rdy); end
        step();
        v_vld = 4'hF;
        #1;
        nvec++; if (vld !== 1'b1 || v_rdy !== 4'b0000 || pld !== 32'h3C2) begin nerr++; $display("FAIL rmid_full: got %b/%b/%h want 1/0000/3c2", vld, v_rdy, pld); end
        rst = 1'b1;
        #1;
        nvec++; if (vld !== 1'b0) begin nerr++; $display("FAIL rmid_async_vld: got %b want 0", vld); end
        nvec++; if (pld !== 32'h0 || v_rdy !== 4'b0000) begin nerr++; $display("FAIL rmid_async_out: got %h/%b want 0/0000", pld, v_rdy); end
        step();
        rst = 1'b0;
        #1;
        nvec++; if (v_rdy !== 4'b0001) begin nerr++; $display("FAIL rmid_ptr0: got %b want 0001", v_rdy); end
        v_vld = 4'h0;
        step();
    endtask

    task automatic test_fixed();
        v_pld0[1] = 32'hF1; v_pld0[3] = 32'hF3;
        v_vld0 = 4'b1010; rdy0 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            nvec++; if (v_rdy0 !== 4'b0010) begin nerr++; $display("FAIL fixed_grant[%0d]: got %b want 0010", k, v_rdy0); end
            step();
            nvec++; if (vld0 !== 1'b1 || sid0 !== 2'd1 || pld0 !== 32'hF1) begin nerr++; $display("FAIL fixed_out[%0d]: got %b/%0d/%h want 1/1/f1", k, vld0, sid0, pld0); end
        end
        v_vld0 = 4'h0;
        step();
    endtask

    task automatic test_random();
        logic [33:0] mq [$];
        logic [3:0]  eg;
        int          mptr;
        int          eidx;
        int          j;
        int          seq [4];
        rst = 1'b1; v_vld = 4'h0; rdy = 1'b0;
        step();
        rst = 1'b0;
        mptr = 0;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int ch = 0; ch < 4; ch++) begin
                v_vld[ch] = 1'($urandom_range(0, 1));
                v_pld[ch] = (32'(ch) << 24) | 32'(seq[ch]);
            end
            rdy = ($urandom_range(0, 3) != 0);
            #1;
            eg = 4'h0; eidx = 0;
            for (int i = 0; i < 4; i++) begin
                j = (mptr + i) % 4;
                if (eg == 4'h0 && v_vld[j]) begin eg[j] = 1'b1; eidx = j; end
            end
            if (mq.size() == 2) eg = 4'h0;
            nvec++; if (v_rdy !== eg) begin nerr++; $display("FAIL rand_grant[%0d]: got %b want %b", cyc, v_rdy, eg); end
            nvec++; if (vld !== (mq.size() != 0)) begin nerr++; $display("FAIL rand_vld[%0d]: got %b want %b", cyc, vld, mq.size() != 0); end
            if (mq.size() != 0) begin
                nvec++; if ({sid, pld} !== mq[0]) begin nerr++; $display("FAIL rand_head[%0d]: got %h want %h", cyc, {sid, pld}, mq[0]); end
                if (rdy) void'(mq.pop_front());
            end
            if (eg != 4'h0) begin
                mq.push_back({2'(eidx), v_pld[eidx]});
                mptr = (eidx + 1) % 4;
                seq[eidx]++;
            end
            step();
        end
        v_vld = 4'h0; rdy = 1'b1;
        step(); step(); step();
        nvec++; if (vld !== 1'b0) begin nerr++; $display("FAIL rand_drain: got %b want 0", vld); end
    endtask

    initial begin
        rst = 1'b1; v_vld = 4'h0; rdy = 1'b0; v_vld0 = 4'h0; rdy0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v_pld[i]  = 32'h0;
            v_pld0[i] = 32'h0;
        end
        test_reset();
        test_round_robin();
        test_hold();
        test_wrap();
        test_drop();
        test_reset_mid();
        test_fixed();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_arb_merge
`default_nettype wire
